bus_burst_master: RTL and testbench
===================================

# bus_burst_master

Pipelined bus initiator that sits on one master port of `bus_intercon`. It accepts a burst command (word address, length, direction), issues pipelined strobes that honour `stall`, and tracks outstanding acknowledges. Read data is buffered in a credit-limited FIFO. Each burst ends with a done pulse and a status code. DMA, instruction prefetch and debug engines use it so they never touch raw bus handshakes.

## Interface
- `LEN_W`, 8: width of burst length and transfer count. Max burst is 2^LEN_W-1 words.
- `DEPTH`, 4: maximum outstanding strobes and read FIFO depth. Power of two, ≥2.
- `TIMEOUT`, 255: idle cycles allowed without progress before abort. 0 disables the timeout.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `cmd_we`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  30  start word address (`WORD_SIZE`-2 bits).
- `cmd_len`  in  LEN_W  number of words.
- `cmd_sel`  in  4  byte select, applied to every beat.
- `wdata_valid` / `wdata_ready`  in / out  1  write data stream handshake.
- `wdata`  in  32  write data.
- `rdata_valid` / `rdata_ready`  out / in  1  read data stream handshake.
- `rdata`  out  32  read data, FIFO head.
- `bus_o`  out  `bus::m2s_s`  addr, data, cyc, stb, we, sel toward the interconnect.
- `bus_i`  in  `bus::s2m_s`  data, ack, err, stall from the interconnect.
- `done`  out  1  one-cycle pulse at burst end.
- `err_code`  out  2  0 = ok, 1 = bus err, 2 = timeout. Held until the next command is accepted.
- `xfer_cnt`  out  LEN_W  words acknowledged in the last or current burst.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset (async) forces IDLE and clears the read FIFO. All of `bus_o` is 0. `rdata_valid`, `done`, `err_code` and `xfer_cnt` are 0.
- **IDLE**
  - `cmd_ready`=1 only when the read FIFO is empty.
  - On accept, latch addr, len, we and sel, clear `xfer_cnt` and `err_code`.
  - len=0 goes to DONE without asserting `cyc`. Otherwise go to ISSUE with `cyc`=1.
- **ISSUE**
  - Eligibility: `stb` is eligible while remaining>0 and outstanding + FIFO count < DEPTH.
  - Reads assert `stb` when eligible. Writes assert `stb` when eligible and `wdata_valid`=1.
  - `bus_o.data` = `wdata` (combinational). `wdata_ready` = `stb` & ~`bus_i.stall`.
  - A beat is accepted when `stb` & ~`stall`. On acceptance, addr increments by 1, remaining decrements, and outstanding increments.
  - While stalled, addr, data, we and sel are held stable.
  - When remaining reaches 0, go to DRAIN.
- **Acks (any state with `cyc`=1)**
  - `ack` decrements outstanding and increments `xfer_cnt`.
  - On reads, `ack` pushes `bus_i.data` into the FIFO.
  - Accept and ack in the same cycle leave outstanding unchanged.
  - An ack with outstanding=0 is ignored.
- **DRAIN**: `stb`=0 and `cyc`=1 until outstanding=0, then go to DONE.
- **err**: `bus_i.err` in ISSUE or DRAIN sets `err_code`=1 and goes to DONE. The erroring beat is not counted.
- **Timeout counter**
  - Counts cycles with `cyc`=1 and no accepted beat and no ack.
  - Clears on any progress.
  - Reaching TIMEOUT sets `err_code`=2 and goes to DONE.
- **DONE**: `cyc`=`stb`=0, `done`=1 for one cycle, then IDLE. Data already in the FIFO is retained for the consumer.
- `cyc` stays continuously high from the first strobe through the last ack, so the interconnect keeps the grant. Acks arriving after `cyc` falls are ignored.
- Read FIFO: a push while full cannot occur (guaranteed by the credit rule). Pop happens on `rdata_valid` & `rdata_ready`. Simultaneous push and pop on a full FIFO is legal.

## Timing
- Command accept to first `stb`: 1 cycle.
- Back-to-back beats: one per cycle when the slave does not stall and credit is available.
- The interconnect returns ack/err 1 cycle after acceptance. With no stall, an N-beat burst has `cyc` high for N+1 cycles. `done` pulses on the cycle after the last ack.
- `err`/timeout abort: `cyc` and `stb` are 0 on the cycle after detection, with `done` in that same cycle.
- Read data: `rdata_valid` rises 1 cycle after the ack that pushed it. Order is preserved.
- A non-granted master sees `stall`=1. This is normal backpressure and counts toward the timeout.

## Test plan
- Read, len=4, addr 0x100, ack 1 cycle after each accept, no stall, `rdata_ready`=1.
  - Expect `stb` on 4 consecutive cycles with addr 0x100–0x103.
  - Expect rdata D0–D3 in order, `done` 1 cycle after the 4th ack, `err_code`=0, `xfer_cnt`=4.
- Write, len=3, `stall`=1 for 2 cycles on beat 2.
  - Expect addr, data and sel stable while stalled, `wdata_ready` high only on the 3 accepted cycles.
  - Expect exactly 3 acks and `xfer_cnt`=3.
- Read, len=8, DEPTH=4, `rdata_ready`=0.
  - Expect exactly 4 beats accepted, then `stb` low with `cyc` high.
  - Raise `rdata_ready`: the remaining 4 beats issue, and all 8 words come out in address order.
- Read, len=4, `err` returned for beat 2.
  - Expect `cyc`=0 the next cycle, a `done` pulse, `err_code`=1, `xfer_cnt`=1, and 1 word in the FIFO.
- TIMEOUT=16, slave never acks.
  - Expect `cyc` dropped after 16 no-progress cycles, `err_code`=2, `done` pulse.
- Edge cases:
  - len=0: `done` with no `cyc` ever asserted.
  - Async `rst` mid-burst: `cyc`/`stb`=0 immediately, FIFO empty, and `cmd_ready`=1 after release.

Source files
------------

// File: rtl/bus_burst_master.sv
// Pipelined burst initiator for one bus_intercon master port: issues strobes under
// stall/credit control, counts acks, buffers read data and reports a status per burst.
module bus_burst_master #(
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [29:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_sel,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [31:0]      wdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [31:0]      rdata,
    output logic [29:0]      bus_o_addr,
    output logic [31:0]      bus_o_data,
    output logic             bus_o_cyc,
    output logic             bus_o_stb,
    output logic             bus_o_we,
    output logic [3:0]       bus_o_sel,
    input  logic [31:0]      bus_i_data,
    input  logic             bus_i_ack,
    input  logic             bus_i_err,
    input  logic             bus_i_stall,
    output logic             done,
    output logic [1:0]       err_code,
    output logic [LEN_W-1:0] xfer_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0]     DEPTH_LIM = (CNT_W + 1)'(DEPTH);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic               TMO_EN    = (TIMEOUT > 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_BUS = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [29:0]      addr_r;
    logic [LEN_W-1:0] rem_r;
    logic [LEN_W-1:0] xfer_cnt_r;
    logic             we_r;
    logic [3:0]       sel_r;
    logic [CNT_W-1:0] outst_r;
    logic [CNT_W-1:0] outst_next_s;
    logic [CNT_W-1:0] fifo_cnt_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [31:0]      mem_r [DEPTH];
    logic [TMO_W-1:0] tmo_r;
    logic [1:0]       err_code_r;
    logic             cyc_r;
    logic             done_r;

    logic             cmd_ready_s;
    logic             cmd_fire_s;
    logic [CNT_W:0]   inflight_s;
    logic             credit_s;
    logic             stb_s;
    logic             accept_s;
    logic             ack_s;
    logic             err_s;
    logic             push_s;
    logic             pop_s;
    logic             progress_s;
    logic             tmo_hit_s;

    // Read FIFO occupancy counts against the outstanding window so a push can never overflow.
    assign inflight_s  = {1'b0, outst_r} + {1'b0, fifo_cnt_r};
    assign credit_s    = (inflight_s < DEPTH_LIM);
    assign cmd_ready_s = (state_r == ST_IDLE) && (fifo_cnt_r == '0);
    assign cmd_fire_s  = cmd_valid && cmd_ready_s;
    assign stb_s       = (state_r == ST_ISSUE) && (rem_r != '0) && credit_s && (!we_r || wdata_valid);
    assign accept_s    = stb_s && !bus_i_stall;
    assign ack_s       = cyc_r && bus_i_ack && (outst_r != '0);
    assign err_s       = cyc_r && bus_i_err;
    assign push_s      = ack_s && !we_r;
    assign pop_s       = (fifo_cnt_r != '0) && rdata_ready;
    assign progress_s  = accept_s || ack_s;
    assign tmo_hit_s   = TMO_EN && cyc_r && !progress_s && (tmo_r == TMO_LAST);

    assign cmd_ready   = cmd_ready_s;
    assign wdata_ready = accept_s && we_r;
    assign rdata_valid = (fifo_cnt_r != '0);
    assign rdata       = mem_r[rd_ptr_r];
    assign bus_o_addr  = addr_r;
    assign bus_o_data  = we_r ? wdata : 32'd0;
    assign bus_o_cyc   = cyc_r;
    assign bus_o_stb   = stb_s;
    assign bus_o_we    = we_r;
    assign bus_o_sel   = sel_r;
    assign done        = done_r;
    assign err_code    = err_code_r;
    assign xfer_cnt    = xfer_cnt_r;

    // Outstanding-strobe bookkeeping: a beat accepted together with an ack nets to zero.
    always_comb begin
        outst_next_s = outst_r;
        case ({accept_s, ack_s})
            2'b10:   outst_next_s = outst_r + CNT_W'(1);
            2'b01:   outst_next_s = outst_r - CNT_W'(1);
            default: outst_next_s = outst_r;
        endcase
    end

    // Burst sequencing; err and timeout abort straight to DONE from either bus state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    state_next_s = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (err_s || tmo_hit_s) begin
                    state_next_s = ST_DONE;
                end else if (accept_s && (rem_r == LEN_W'(1))) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (err_s || tmo_hit_s || (outst_next_s == '0)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Control, address and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= 30'd0;
            rem_r      <= '0;
            we_r       <= 1'b0;
            sel_r      <= 4'd0;
            outst_r    <= '0;
            xfer_cnt_r <= '0;
            err_code_r <= ERR_OK;
            tmo_r      <= '0;
            cyc_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cyc_r   <= (state_next_s == ST_ISSUE) || (state_next_s == ST_DRAIN);
            done_r  <= (state_next_s == ST_DONE);
            if (!TMO_EN || !cyc_r || progress_s) begin
                tmo_r <= '0;
            end else begin
                tmo_r <= tmo_r + TMO_W'(1);
            end
            if (cmd_fire_s) begin
                addr_r     <= cmd_addr;
                rem_r      <= cmd_len;
                we_r       <= cmd_we;
                sel_r      <= cmd_sel;
                outst_r    <= '0;
                xfer_cnt_r <= '0;
                err_code_r <= ERR_OK;
            end else begin
                if (accept_s) begin
                    addr_r <= addr_r + 30'd1;
                    rem_r  <= rem_r - LEN_W'(1);
                end
                outst_r <= outst_next_s;
                if (ack_s) begin
                    xfer_cnt_r <= xfer_cnt_r + LEN_W'(1);
                end
                if (err_s) begin
                    err_code_r <= ERR_BUS;
                end else if (tmo_hit_s) begin
                    err_code_r <= ERR_TMO;
                end
            end
        end
    end

    // Read FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Read FIFO storage; contents are only meaningful behind the reset-cleared pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus_i_data;
        end
    end

endmodule

// File: tb/tb_bus_burst_master.sv
// Self-checking bench for bus_burst_master: a behavioural slave plus a burst-level
// reference model (expected addresses, data, counts and status derived per burst).
module tb_bus_burst_master;
    localparam int LEN_W   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_we;
    logic [29:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [3:0]       cmd_sel;
    logic             wdata_valid, wdata_ready;
    logic [31:0]      wdata;
    logic             rdata_valid, rdata_ready;
    logic [31:0]      rdata;
    logic [29:0]      bus_o_addr;
    logic [31:0]      bus_o_data;
    logic             bus_o_cyc, bus_o_stb, bus_o_we;
    logic [3:0]       bus_o_sel;
    logic [31:0]      bus_i_data;
    logic             bus_i_ack, bus_i_err, bus_i_stall;
    logic             done;
    logic [1:0]       err_code;
    logic [LEN_W-1:0] xfer_cnt;

    always #5 clk = ~clk;

    bus_burst_master #(.LEN_W(LEN_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .bus_o_addr(bus_o_addr), .bus_o_data(bus_o_data), .bus_o_cyc(bus_o_cyc),
        .bus_o_stb(bus_o_stb), .bus_o_we(bus_o_we), .bus_o_sel(bus_o_sel),
        .bus_i_data(bus_i_data), .bus_i_ack(bus_i_ack), .bus_i_err(bus_i_err),
        .bus_i_stall(bus_i_stall),
        .done(done), .err_code(err_code), .xfer_cnt(xfer_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    // burst request and slave behaviour
    bit          b_we;
    logic [29:0] b_addr;
    int          b_len;
    logic [3:0]  b_sel;
    int          err_beat, stall_beat, stall_len, st_done, rmode;
    bit          mute, rand_stall, cmd_pend;
    bit          resp_pend, resp_err;
    logic [31:0] resp_data;
    logic [31:0] wq[$];
    int          widx;

    // observations
    logic [29:0] acc_addr[$];
    logic [31:0] acc_data[$];
    logic [3:0]  acc_sel[$];
    int          acc_cycle[$];
    logic [31:0] got_q[$];
    int          cyc_no = 0;
    int          cmd_cycle, done_cycle, last_cyc_cycle, done_cnt, cyc_cnt, wready_cnt;
    bit          prev_stalled;
    logic [29:0] prev_addr;
    logic [31:0] prev_data;
    logic [3:0]  prev_sel;

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_no++;
        cmd_valid   = cmd_pend;
        bus_i_ack   = resp_pend && !resp_err;
        bus_i_err   = resp_pend && resp_err;
        bus_i_data  = resp_pend ? resp_data : 32'd0;
        bus_i_stall = ((acc_addr.size() == stall_beat) && (st_done < stall_len)) ||
                      (rand_stall && ($urandom_range(0, 3) == 0));
        rdata_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        wdata_valid = (widx < wq.size());
        wdata       = wdata_valid ? wq[widx] : 32'd0;
        #1;
        if (prev_stalled) begin
            check("stall_hold_stb", bus_o_stb, 1'b1);
            check("stall_hold_addr", bus_o_addr, prev_addr);
            check("stall_hold_sel", bus_o_sel, prev_sel);
            if (b_we) check("stall_hold_data", bus_o_data, prev_data);
        end
        prev_stalled = bus_o_stb && bus_i_stall;
        prev_addr = bus_o_addr;
        prev_data = bus_o_data;
        prev_sel  = bus_o_sel;
        resp_pend = 1'b0;
        if (bus_o_stb && !bus_i_stall) begin
            resp_pend = !mute;
            resp_err  = (acc_addr.size() == err_beat);
            resp_data = mem_word(bus_o_addr);
            acc_addr.push_back(bus_o_addr);
            acc_data.push_back(bus_o_data);
            acc_sel.push_back(bus_o_sel);
            acc_cycle.push_back(cyc_no);
        end
        if (bus_o_stb && bus_i_stall) st_done++;
        if (wdata_ready) begin
            wready_cnt++;
            widx++;
        end
        if (rdata_valid && rdata_ready) got_q.push_back(rdata);
        if (bus_o_cyc) begin
            cyc_cnt++;
            last_cyc_cycle = cyc_no;
        end
        if (done) begin
            done_cnt++;
            done_cycle = cyc_no;
        end
        if (cmd_valid && cmd_ready) begin
            cmd_pend  = 1'b0;
            cmd_cycle = cyc_no;
        end
    endtask

    task automatic start_burst(input bit we, input logic [29:0] addr, input int len,
                               input logic [3:0] sel, input int eb, input bit mt,
                               input int sb, input int sl, input bit rs, input int rm);
        b_we = we; b_addr = addr; b_len = len; b_sel = sel;
        err_beat = eb; mute = mt; stall_beat = sb; stall_len = sl;
        rand_stall = rs; rmode = rm;
        wq.delete();
        for (int i = 0; i < len; i++) wq.push_back($urandom);
        widx = 0;
        if (!we) wq.delete();
        acc_addr.delete(); acc_data.delete(); acc_sel.delete(); acc_cycle.delete();
        got_q.delete();
        prev_stalled = 1'b0; st_done = 0; done_cnt = 0; cyc_cnt = 0; wready_cnt = 0;
        cmd_cycle = -1; done_cycle = -1; last_cyc_cycle = -1;
        cmd_we = we; cmd_addr = addr; cmd_len = LEN_W'(len); cmd_sel = sel;
        cmd_pend = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 800) begin
            cycle();
            n++;
        end
        check("done_seen", (done_cnt != 0), 1'b1);
    endtask

    task automatic drain();
        rmode = 0;
        rand_stall = 1'b0;
        repeat (2 * DEPTH + 2) cycle();
        check("fifo_drained", rdata_valid, 1'b0);
    endtask

    // Burst-level reference: which beats, which words and which status this burst must produce.
    task automatic verify();
        int exp_err, exp_xfer, exp_beats, bad_a, bad_d, bad_r, n;
        exp_err  = mute ? 2 : ((err_beat >= 0 && err_beat < b_len) ? 1 : 0);
        exp_xfer = (exp_err == 2) ? 0 : ((exp_err == 1) ? err_beat : b_len);
        check("err_code", err_code, exp_err);
        check("xfer_cnt", xfer_cnt, exp_xfer);
        check("done_pulses", done_cnt, 1);
        bad_a = 0; bad_d = 0; bad_r = 0;
        for (int i = 0; i < acc_addr.size(); i++) begin
            if (acc_addr[i] !== b_addr + 30'(i)) bad_a++;
            if (acc_sel[i] !== b_sel) bad_a++;
            if (b_we && (i >= wq.size() || acc_data[i] !== wq[i])) bad_d++;
        end
        check("beat_addr_sel", bad_a, 0);
        check("beat_wdata", bad_d, 0);
        if (exp_err != 1) begin
            exp_beats = (exp_err == 2) ? ((b_len < DEPTH) ? b_len : DEPTH) : b_len;
            check("beat_count", acc_addr.size(), exp_beats);
        end
        if (b_len == 0) check("no_cyc", cyc_cnt, 0);
        else check("cyc_fall_to_done", done_cycle - last_cyc_cycle, 1);
        if (b_we) begin
            check("wready_beats", wready_cnt, acc_addr.size());
            check("rd_words", got_q.size(), 0);
        end else begin
            check("rd_words", got_q.size(), exp_xfer);
            n = (got_q.size() < exp_xfer) ? got_q.size() : exp_xfer;
            for (int i = 0; i < n; i++)
                if (got_q[i] !== mem_word(b_addr + 30'(i))) bad_r++;
            check("rd_data_order", bad_r, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 30'd0; cmd_len = '0; cmd_sel = 4'd0;
        wdata_valid = 1'b0; wdata = 32'd0; rdata_ready = 1'b0;
        bus_i_data = 32'd0; bus_i_ack = 1'b0; bus_i_err = 1'b0; bus_i_stall = 1'b0;
        cmd_pend = 1'b0; resp_pend = 1'b0; resp_err = 1'b0; mute = 1'b0; rand_stall = 1'b0;
        err_beat = -1; stall_beat = -1; stall_len = 0; st_done = 0; rmode = 2; widx = 0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_cyc", bus_o_cyc, 1'b0);
        check("rst_stb", bus_o_stb, 1'b0);
        check("rst_addr", bus_o_addr, 30'd0);
        check("rst_rvalid", rdata_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_code, 2'd0);
        check("rst_xfer", xfer_cnt, 0);

        // plain 4-beat read, no stall
        start_burst(1'b0, 30'h100, 4, 4'hf, -1, 1'b0, -1, 0, 1'b0, 0);
        wait_done();
        if (acc_cycle.size() == 4) begin
            check("first_stb_latency", acc_cycle[0] - cmd_cycle, 1);
            check("back_to_back", acc_cycle[3] - acc_cycle[0], 3);
            check("done_after_last_ack", done_cycle - acc_cycle[3], 2);
        end
        check("cyc_len_plus_1", cyc_cnt, 5);
        drain();
        verify();

        // 3-beat write, beat 2 stalled for 2 cycles
        start_burst(1'b1, 30'h2000, 3, 4'h5, -1, 1'b0, 1, 2, 1'b0, 0);
        wait_done();
        check("stall_cycles", st_done, 2);
        drain();
        verify();

        // 8-beat read against a blocked consumer: credit stops issue at DEPTH
        start_burst(1'b0, 30'h40, 8, 4'hf, -1, 1'b0, -1, 0, 1'b0, 2);
        repeat (12) cycle();
        check("credit_beats", acc_addr.size(), DEPTH);
        check("credit_cyc", bus_o_cyc, 1'b1);
        check("credit_stb", bus_o_stb, 1'b0);
        rmode = 0;
        wait_done();
        drain();
        verify();

        // bus error on beat 2 of a 4-beat read
        start_burst(1'b0, 30'h500, 4, 4'h3, 1, 1'b0, -1, 0, 1'b0, 2);
        wait_done();
        cycle();
        check("err_fifo_holds", rdata_valid, 1'b1);
        check("err_cmd_blocked", cmd_ready, 1'b0);
        drain();
        verify();

        // silent slave: timeout abort
        start_burst(1'b0, 30'h600, 10, 4'hf, -1, 1'b1, -1, 0, 1'b0, 0);
        wait_done();
        if (acc_cycle.size() > 0)
            check("timeout_span", last_cyc_cycle - acc_cycle[acc_cycle.size() - 1], TIMEOUT);
        drain();
        verify();

        // zero-length command
        start_burst(1'b1, 30'h700, 0, 4'hf, -1, 1'b0, -1, 0, 1'b0, 0);
        wait_done();
        drain();
        verify();

        // randomized bursts
        for (int k = 0; k < 14; k++) begin
            int len, eb;
            len = (k % 5 == 0) ? 0 : int'($urandom_range(1, 20));
            eb  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            start_burst(1'($urandom_range(0, 1)), 30'($urandom), len, 4'($urandom), eb,
                        1'b0, -1, 0, 1'b1, 1);
            wait_done();
            drain();
            verify();
        end

        // async reset in the middle of a read burst
        start_burst(1'b0, 30'h800, 8, 4'hf, -1, 1'b0, -1, 0, 1'b0, 2);
        repeat (6) cycle();
        #3 rst = 1'b1;
        #1;
        check("arst_cyc", bus_o_cyc, 1'b0);
        check("arst_stb", bus_o_stb, 1'b0);
        check("arst_fifo", rdata_valid, 1'b0);
        check("arst_done", done, 1'b0);
        resp_pend = 1'b0;
        cmd_pend = 1'b0;
        repeat (2) cycle();
        #3 rst = 1'b0;
        cycle();
        check("arst_cmd_ready", cmd_ready, 1'b1);
        check("arst_fifo_after", rdata_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
